ibex_data_bridge: RTL and testbench

Sequential adapter directly downstream of the Ibex core's data memory port. It converts the core's req/gnt/rvalid protocol into a valid/ready request channel (A) and a valid response channel (D) for the system interconnect. It tracks outstanding transactions with a credit counter and registers every response before returning it to the core. It also flags responses that arrive with no transaction outstanding.

---
 rtl/ibex_data_bridge_if.sv | 58 +++++
 rtl/ibex_data_bridge.sv | 157 +++++++++++++++
 tb/tb_ibex_data_bridge.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ibex_data_bridge_if.sv
// Bundle of the Ibex data port, the A request channel and the D response channel.
// Signal names keep the bridge's point of view: _i means an input to the bridge
// and _o an output of the bridge.
// Modports:
//   slave  - the bridge itself.
//   master - the environment, which drives the core side and the bus side.
// Parameters: ADDR_W (address width), DATA_W (data width; mask width DATA_W/8).
interface ibex_data_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  // Core data port
  logic              data_req_i;
  logic              data_gnt_o;
  logic              data_we_i;
  logic [BE_W-1:0]   data_be_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic              data_rvalid_o;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_err_o;

  // Request channel A
  logic              a_valid_o;
  logic              a_ready_i;
  logic              a_write_o;
  logic [BE_W-1:0]   a_mask_o;
  logic [ADDR_W-1:0] a_addr_o;
  logic [DATA_W-1:0] a_data_o;

  // Response channel D
  logic              d_valid_i;
  logic [DATA_W-1:0] d_data_i;
  logic              d_error_i;
  logic              d_ready_o;

  logic              protocol_err_o;

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    output a_valid_o, a_write_o, a_mask_o, a_addr_o, a_data_o,
    input  a_ready_i,
    input  d_valid_i, d_data_i, d_error_i,
    output d_ready_o, protocol_err_o
  );

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
    input  a_valid_o, a_write_o, a_mask_o, a_addr_o, a_data_o,
    output a_ready_i,
    output d_valid_i, d_data_i, d_error_i,
    input  d_ready_o, protocol_err_o
  );
endinterface

// File: rtl/ibex_data_bridge.sv
// ibex_data_bridge: converts the Ibex data port protocol (req/gnt/rvalid) into a
// valid/ready request channel (A) and a valid-only response channel (D).
// A credit counter bounds the number of granted-but-unanswered transactions.
// Every response is registered, so the core sees it one cycle after d_valid_i.
// A response that arrives with nothing outstanding is dropped, and it sets the
// sticky protocol_err_o flag.
// Ports:
//   clk_i, rst_ni - clock and asynchronous active-low reset.
//   bus           - ibex_data_bridge_if.slave: core port, A channel and D channel.
// Parameters: MAX_OUTSTANDING (1..7), ADDR_W, DATA_W.
// Optional macro IBEX_DATA_BRIDGE_REQ_REG_EN inserts a one-entry request
// register on the A channel. This removes the combinational core-to-bus path
// and adds one cycle of request latency.
module ibex_data_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  ibex_data_bridge_if.slave   bus
);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              credit_ok;
  logic              rsp_acc;
  logic              cnt_inc;

  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              perr_q, perr_d;

  assign credit_ok = (cnt_q < CNT_MAX);
  // A response counts only while something is outstanding.
  assign rsp_acc   = bus.d_valid_i & (cnt_q != '0);

`ifdef IBEX_DATA_BRIDGE_REQ_REG_EN
  logic              slot_vld_q, slot_vld_d;
  logic              slot_we_q, slot_we_d;
  logic [BE_W-1:0]   slot_be_q, slot_be_d;
  logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [DATA_W-1:0] slot_wdata_q, slot_wdata_d;
  logic              gnt;

  // The slot accepts a new request when it is empty or is draining this cycle.
  assign gnt = bus.data_req_i & (~slot_vld_q | bus.a_ready_i) & credit_ok;

  // Request slot: load on gnt, and clear the payload once it drains.
  always_comb begin
    slot_vld_d   = slot_vld_q;
    slot_we_d    = slot_we_q;
    slot_be_d    = slot_be_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    if (gnt) begin
      slot_vld_d   = 1'b1;
      slot_we_d    = bus.data_we_i;
      slot_be_d    = bus.data_be_i;
      slot_addr_d  = bus.data_addr_i;
      slot_wdata_d = bus.data_wdata_i;
    end else if (slot_vld_q && bus.a_ready_i) begin
      slot_vld_d   = 1'b0;
      slot_we_d    = 1'b0;
      slot_be_d    = '0;
      slot_addr_d  = '0;
      slot_wdata_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_vld_q   <= 1'b0;
      slot_we_q    <= 1'b0;
      slot_be_q    <= '0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
    end else begin
      slot_vld_q   <= slot_vld_d;
      slot_we_q    <= slot_we_d;
      slot_be_q    <= slot_be_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
    end
  end

  // Credit is taken when the core is granted, not when the bus accepts.
  assign cnt_inc        = gnt;
  assign bus.data_gnt_o = gnt;
  assign bus.a_valid_o  = slot_vld_q;
  assign bus.a_write_o  = slot_we_q;
  assign bus.a_mask_o   = slot_be_q;
  assign bus.a_addr_o   = slot_addr_q;
  assign bus.a_data_o   = slot_wdata_q;
`else
  logic              a_valid;
  logic [ADDR_W-1:0] addr_pass;

  // Pass-through path. The payload is zeroed while a_valid_o is low.
  assign a_valid        = bus.data_req_i & credit_ok;
  assign addr_pass      = a_valid ? bus.data_addr_i : '0;
  assign cnt_inc        = a_valid & bus.a_ready_i;
  assign bus.data_gnt_o = cnt_inc;
  assign bus.a_valid_o  = a_valid;
  assign bus.a_write_o  = a_valid & bus.data_we_i;
  assign bus.a_mask_o   = a_valid ? bus.data_be_i    : '0;
  assign bus.a_addr_o   = addr_pass;
  assign bus.a_data_o   = a_valid ? bus.data_wdata_i : '0;
`endif

  // Credit counter: a simultaneous issue and response leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({cnt_inc, rsp_acc})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Response register, plus the sticky flag for unexpected responses.
  always_comb begin
    rvalid_d = rsp_acc;
    rdata_d  = rdata_q;
    err_d    = err_q;
    perr_d   = perr_q | (bus.d_valid_i & (cnt_q == '0));
    if (rsp_acc) begin
      rdata_d = bus.d_data_i;
      err_d   = bus.d_error_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      perr_q   <= perr_d;
    end
  end

  assign bus.data_rvalid_o  = rvalid_q;
  assign bus.data_rdata_o   = rdata_q;
  assign bus.data_err_o     = err_q;
  assign bus.d_ready_o      = 1'b1;
  assign bus.protocol_err_o = perr_q;
endmodule

// File: tb/tb_ibex_data_bridge.sv
// Directed testbench for ibex_data_bridge in its default (pass-through) build,
// with MAX_OUTSTANDING=2.
// Inputs are driven just after the falling edge. Outputs are checked 1 time
// unit later, well away from the rising edge.
module tb_ibex_data_bridge;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  ibex_data_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  ibex_data_bridge #(
    .MAX_OUTSTANDING(2),
    .ADDR_W         (32),
    .DATA_W         (32)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic req, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic ardy, input logic dv, input logic [31:0] dd,
                      input logic de);
    @(negedge clk);
    bus_if.data_req_i   = req;
    bus_if.data_we_i    = we;
    bus_if.data_be_i    = be;
    bus_if.data_addr_i  = addr;
    bus_if.data_wdata_i = wdata;
    bus_if.a_ready_i    = ardy;
    bus_if.d_valid_i    = dv;
    bus_if.d_data_i     = dd;
    bus_if.d_error_i    = de;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] addr);
    step(1'b1, 1'b0, 4'hF, addr, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic rsp(input logic [31:0] dd, input logic de);
    step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b1, dd, de);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt"},    32'(bus_if.data_gnt_o),     32'h0);
    chk({tag, "_rvalid"}, 32'(bus_if.data_rvalid_o),  32'h0);
    chk({tag, "_rdata"},  bus_if.data_rdata_o,        32'h0);
    chk({tag, "_err"},    32'(bus_if.data_err_o),     32'h0);
    chk({tag, "_avalid"}, 32'(bus_if.a_valid_o),      32'h0);
    chk({tag, "_aaddr"},  bus_if.a_addr_o,            32'h0);
    chk({tag, "_amask"},  32'(bus_if.a_mask_o),       32'h0);
    chk({tag, "_dready"}, 32'(bus_if.d_ready_o),      32'h1);
    chk({tag, "_perr"},   32'(bus_if.protocol_err_o), 32'h0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus_if.data_req_i   = 1'b0;
    bus_if.data_we_i    = 1'b0;
    bus_if.data_be_i    = 4'h0;
    bus_if.data_addr_i  = 32'h0;
    bus_if.data_wdata_i = 32'h0;
    bus_if.a_ready_i    = 1'b0;
    bus_if.d_valid_i    = 1'b0;
    bus_if.d_data_i     = 32'h0;
    bus_if.d_error_i    = 1'b0;
    #3;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // Single read: grant in the same cycle, response one cycle after d_valid_i
    rd(32'h100);
    chk("t1_gnt",    32'(bus_if.data_gnt_o), 32'h1);
    chk("t1_avalid", 32'(bus_if.a_valid_o),  32'h1);
    chk("t1_aaddr",  bus_if.a_addr_o,        32'h100);
    chk("t1_amask",  32'(bus_if.a_mask_o),   32'hF);
    chk("t1_awrite", 32'(bus_if.a_write_o),  32'h0);
    idle();
    chk("t1_idle_gnt",   32'(bus_if.data_gnt_o), 32'h0);
    chk("t1_idle_aaddr", bus_if.a_addr_o,        32'h0);
    rsp(32'hDEADBEEF, 1'b0);
    chk("t1_rvalid_early", 32'(bus_if.data_rvalid_o), 32'h0);
    idle();
    chk("t1_rvalid", 32'(bus_if.data_rvalid_o),  32'h1);
    chk("t1_rdata",  bus_if.data_rdata_o,        32'hDEADBEEF);
    chk("t1_err",    32'(bus_if.data_err_o),     32'h0);
    chk("t1_perr",   32'(bus_if.protocol_err_o), 32'h0);
    idle();
    chk("t1_rvalid_pulse", 32'(bus_if.data_rvalid_o), 32'h0);
    chk("t1_rdata_hold",   bus_if.data_rdata_o,       32'hDEADBEEF);

    // Credit limit: the third request is held until a response returns credit
    rd(32'h200);
    chk("t2_gnt0", 32'(bus_if.data_gnt_o), 32'h1);
    rd(32'h204);
    chk("t2_gnt1", 32'(bus_if.data_gnt_o), 32'h1);
    rd(32'h208);
    chk("t2_full_avalid", 32'(bus_if.a_valid_o),  32'h0);
    chk("t2_full_gnt",    32'(bus_if.data_gnt_o), 32'h0);
    rd(32'h208);
    chk("t2_full2_avalid", 32'(bus_if.a_valid_o), 32'h0);
    step(1'b1, 1'b0, 4'hF, 32'h208, 32'h0, 1'b1, 1'b1, 32'h11111111, 1'b0);
    chk("t2_nosame_avalid", 32'(bus_if.a_valid_o),  32'h0);
    chk("t2_nosame_gnt",    32'(bus_if.data_gnt_o), 32'h0);
    rd(32'h208);
    chk("t2_rel_avalid", 32'(bus_if.a_valid_o),     32'h1);
    chk("t2_rel_gnt",    32'(bus_if.data_gnt_o),    32'h1);
    chk("t2_rvalid",     32'(bus_if.data_rvalid_o), 32'h1);
    chk("t2_rdata",      bus_if.data_rdata_o,       32'h11111111);

    // Simultaneous handshake and response at cnt==1 leave cnt at 1
    rsp(32'h22222222, 1'b0);
    chk("t3_gnt_none", 32'(bus_if.data_gnt_o), 32'h0);
    step(1'b1, 1'b0, 4'hF, 32'h300, 32'h0, 1'b1, 1'b1, 32'h33333333, 1'b0);
    chk("t3_sim_gnt", 32'(bus_if.data_gnt_o),    32'h1);
    chk("t3_rvalid0", 32'(bus_if.data_rvalid_o), 32'h1);
    chk("t3_rdata0",  bus_if.data_rdata_o,       32'h22222222);
    rd(32'h304);
    chk("t3_gnt_after", 32'(bus_if.data_gnt_o),    32'h1);
    chk("t3_rvalid1",   32'(bus_if.data_rvalid_o), 32'h1);
    chk("t3_rdata1",    bus_if.data_rdata_o,       32'h33333333);
    rd(32'h308);
    chk("t3_full_avalid", 32'(bus_if.a_valid_o), 32'h0);
    rsp(32'h44444444, 1'b0);
    rsp(32'h55555555, 1'b0);
    chk("t3_drain_rdata", bus_if.data_rdata_o, 32'h44444444);

    // Error response on a write, then an unexpected response
    step(1'b1, 1'b1, 4'h3, 32'h400, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t4_gnt",    32'(bus_if.data_gnt_o), 32'h1);
    chk("t4_awrite", 32'(bus_if.a_write_o),  32'h1);
    chk("t4_adata",  bus_if.a_data_o,        32'hCAFEF00D);
    chk("t4_amask",  32'(bus_if.a_mask_o),   32'h3);
    chk("t4_rdata_prev", bus_if.data_rdata_o, 32'h55555555);
    rsp(32'h0, 1'b1);
    idle();
    chk("t4_rvalid", 32'(bus_if.data_rvalid_o), 32'h1);
    chk("t4_err",    32'(bus_if.data_err_o),    32'h1);
    chk("t4_rdata",  bus_if.data_rdata_o,       32'h0);
    rsp(32'h99999999, 1'b0);
    chk("t4_rvalid_gone", 32'(bus_if.data_rvalid_o), 32'h0);
    idle();
    chk("t4_unexp_rvalid", 32'(bus_if.data_rvalid_o),  32'h0);
    chk("t4_unexp_perr",   32'(bus_if.protocol_err_o), 32'h1);
    chk("t4_unexp_rdata",  bus_if.data_rdata_o,        32'h0);
    chk("t4_unexp_err",    32'(bus_if.data_err_o),     32'h1);
    idle();
    chk("t4_perr_sticky", 32'(bus_if.protocol_err_o), 32'h1);

    // Backpressure: no grant and a stable payload while a_ready_i is low
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 4'hF, 32'h500, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("t5_bp_gnt",    32'(bus_if.data_gnt_o), 32'h0);
      chk("t5_bp_avalid", 32'(bus_if.a_valid_o),  32'h1);
      chk("t5_bp_aaddr",  bus_if.a_addr_o,        32'h500);
    end
    rd(32'h500);
    chk("t5_accept_gnt", 32'(bus_if.data_gnt_o), 32'h1);

    // Reset with two transactions outstanding
    rd(32'h504);
    chk("t6_gnt", 32'(bus_if.data_gnt_o), 32'h1);
    rd(32'h508);
    chk("t6_full_avalid", 32'(bus_if.a_valid_o), 32'h0);
    @(negedge clk);
    #1;
    bus_if.data_req_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    @(negedge clk);
    rst_n = 1'b1;
    rsp(32'h77777777, 1'b0);
    idle();
    chk("t6_late_perr",   32'(bus_if.protocol_err_o), 32'h1);
    chk("t6_late_rvalid", 32'(bus_if.data_rvalid_o),  32'h0);
    chk("t6_late_rdata",  bus_if.data_rdata_o,        32'h0);
    rd(32'h600);
    chk("t6_cnt0_gnt0", 32'(bus_if.data_gnt_o), 32'h1);
    rd(32'h604);
    chk("t6_cnt0_gnt1", 32'(bus_if.data_gnt_o), 32'h1);
    rd(32'h608);
    chk("t6_cnt0_full", 32'(bus_if.a_valid_o), 32'h0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
